// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
//   Sequential multiply/divide unit. One radix-2 step per clock on operand
//   magnitudes (shift-add multiply, restoring divide), followed by one cycle
//   of sign correction. Latency is fixed at WIDTH+1 cycles from the accepting
//   edge, independent of operand values.
//
// Parameters
//   WIDTH    operand/result width (>= 4)
//
// Ports
//   clk      clock, rising edge
//   reset    asynchronous active-high reset
//   Start    begin an operation (accepted only while idle)
//   Div      0 = multiply, 1 = divide
//   Sign     1 = two's complement operands, 0 = unsigned
//   A        multiplicand / dividend
//   B        multiplier / divisor
//   Busy     operation in progress
//   Done     one-cycle pulse: Hi/Lo/DivZero have just been written
//   Hi       product upper half / remainder
//   Lo       product lower half / quotient
//   DivZero  last completed divide had B = 0
// ---------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Div,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_step;
    logic               w_fix;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg_a;     // A was negative (signed op only)
    logic               r_neg_b;     // B was negative (signed op only)
    logic [WIDTH-1:0]   r_a;         // raw dividend, returned on divide by zero
    logic [WIDTH-1:0]   r_bmag;      // |B|: addend for multiply, divisor for divide
    logic [WIDTH-1:0]   r_work_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0]   r_work_lo;   // multiplier bits out / quotient bits in
    logic               r_done;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Magnitudes: -2^(WIDTH-1) negates to 2^(WIDTH-1), still representable unsigned.
    assign w_a_mag = (Sign && A[WIDTH-1]) ? -A : A;
    assign w_b_mag = (Sign && B[WIDTH-1]) ? -B : B;

    // Shift-add step: the carry out of the add becomes the new top bit.
    assign w_mul_sum = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_bmag} : '0);

    // Restoring step. The shifted remainder can need WIDTH+1 bits, but the
    // difference is below the divisor whenever it is kept, so WIDTH bits suffice.
    assign w_div_shift = {r_work_hi, r_work_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_bmag});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_bmag;

    assign w_prod_mag = {r_work_hi, r_work_lo};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod_mag : w_prod_mag;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_fix        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: every datapath and result register is cleared by reset, so an
    // aborted operation leaves no stale operands or results behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_div      <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_a        <= '0;
            r_bmag     <= '0;
            r_work_hi  <= '0;
            r_work_lo  <= '0;
            r_done     <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= w_fix;

            if (w_accept) begin
                r_cnt     <= CNT_W'(WIDTH - 1);
                r_div     <= Div;
                r_neg_a   <= Sign & A[WIDTH-1];
                r_neg_b   <= Sign & B[WIDTH-1];
                r_a       <= A;
                r_bmag    <= w_b_mag;
                r_work_hi <= '0;
                r_work_lo <= w_a_mag;
            end

            if (w_step) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (r_div) begin
                    r_work_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                    r_work_lo <= {r_work_lo[WIDTH-2:0], w_div_ge};
                end else begin
                    r_work_hi <= w_mul_sum[WIDTH:1];
                    r_work_lo <= {w_mul_sum[0], r_work_lo[WIDTH-1:1]};
                end
            end

            if (w_fix) begin
                if (r_div && (r_bmag == '0)) begin
                    r_res_hi   <= r_a;
                    r_res_lo   <= '1;
                    r_div_zero <= 1'b1;
                end else if (r_div) begin
                    // Remainder follows the dividend; quotient follows A xor B.
                    r_res_hi   <= r_neg_a ? -r_work_hi : r_work_hi;
                    r_res_lo   <= (r_neg_a ^ r_neg_b) ? -r_work_lo : r_work_lo;
                    r_div_zero <= 1'b0;
                end else begin
                    r_res_hi   <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_res_lo   <= w_prod_fix[WIDTH-1:0];
                    r_div_zero <= 1'b0;
                end
            end
        end
    end

    assign Busy    = (r_state != S_IDLE);
    assign Done    = r_done;
    assign Hi      = r_res_hi;
    assign Lo      = r_res_lo;
    assign DivZero = r_div_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv
//   Bench for alu_muldiv. A WIDTH=32 instance is checked every cycle against
//   an arithmetic model (expected Busy window, Done timing, held results);
//   a WIDTH=8 instance runs scaled directed cases with a latency check.
// ---------------------------------------------------------------------------
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start, Div, Sign;
    logic [31:0] A, B;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;

    logic        Start8, Div8, Sign8;
    logic [7:0]  A8, B8;
    logic        Busy8, Done8, DivZero8;
    logic [7:0]  Hi8, Lo8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          busy_end = 0;   // Busy expected while cyc < busy_end
    logic [31:0] held_hi  = '0;
    logic [31:0] held_lo  = '0;
    logic        held_dz  = 1'b0;
    logic        cmp_done;
    exp_t        cmp_ent;

    alu_muldiv #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .Start(Start), .Div(Div), .Sign(Sign),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
        .DivZero(DivZero)
    );

    alu_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .Start(Start8), .Div(Div8), .Sign(Sign8),
        .A(A8), .B(B8), .Busy(Busy8), .Done(Done8), .Hi(Hi8), .Lo(Lo8),
        .DivZero(DivZero8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Result from the arithmetic definition: {DivZero, Hi, Lo} for width w.
    function automatic logic [64:0] model(input logic div, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input int w);
        logic [63:0] mask;
        logic [63:0] up;
        longint      sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        if (!div) begin
            p  = sa * sb;
            up = p;
            return {1'b0, 32'((up >> w) & mask), 32'(up & mask)};
        end
        if (b == 32'd0) return {1'b1, a, 32'(mask)};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r & mask), 32'(q & mask)};
    endfunction

    // Per-cycle compare for the 32-bit instance.
    always @(negedge clk) begin
        cmp_done = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            cmp_ent  = exp_q.pop_front();
            cmp_done = 1'b1;
            held_hi  = cmp_ent.hi;
            held_lo  = cmp_ent.lo;
            held_dz  = cmp_ent.dz;
        end
        check("busy",    Busy,    cyc < busy_end);
        check("done",    Done,    cmp_done);
        check("hi",      Hi,      held_hi);
        check("lo",      Lo,      held_lo);
        check("divzero", DivZero, held_dz);
    end

    // Called at posedge+1; Start is sampled on the next edge.
    task automatic issue(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        exp_t        e;
        Div = div; Sign = sgn; A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        A = $urandom; B = $urandom; Div = $urandom_range(0, 1); Sign = $urandom_range(0, 1);
        if (cyc > busy_end) begin
            m     = model(div, sgn, a, b, 32);
            e.due = cyc + 33;
            e.dz  = m[64];
            e.hi  = m[63:32];
            e.lo  = m[31:0];
            exp_q.push_back(e);
            busy_end = cyc + 33;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < busy_end && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL idle_wait: got timeout after %0d cycles expected idle", n);
        end
    endtask

    // Directed 32-bit case with hand-computed expectations; issued while idle.
    task automatic dir(input string name, input logic div, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit_hi, input logic [31:0] lit_lo, input logic lit_dz);
        int n = 0;
        check({name, "_model"}, model(div, sgn, a, b, 32), {lit_dz, lit_hi, lit_lo});
        issue(div, sgn, a, b);
        while (!Done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, 33);
        check({name, "_hi"}, Hi, lit_hi);
        check({name, "_lo"}, Lo, lit_lo);
        check({name, "_dz"}, DivZero, lit_dz);
    endtask

    task automatic run8(input string name, input logic div, input logic sgn,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] lit_hi, input logic [7:0] lit_lo, input logic lit_dz);
        logic [64:0] m;
        int          n = 0;
        m = model(div, sgn, {24'd0, a}, {24'd0, b}, 8);
        check({name, "_model8"}, {m[64], m[39:32], m[7:0]}, {lit_dz, lit_hi, lit_lo});
        Div8 = div; Sign8 = sgn; A8 = a; B8 = b; Start8 = 1'b1;
        @(posedge clk); #1;
        Start8 = 1'b0; A8 = 8'h5A; B8 = 8'hA5;
        check({name, "_busy8"}, Busy8, 1'b1);
        while (!Done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency8"}, n, 9);
        check({name, "_hi8"}, Hi8, lit_hi);
        check({name, "_lo8"}, Lo8, lit_lo);
        check({name, "_dz8"}, DivZero8, lit_dz);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Start = 1'b0; Div = 1'b0; Sign = 1'b0; A = '0; B = '0;
        Start8 = 1'b0; Div8 = 1'b0; Sign8 = 1'b0; A8 = '0; B8 = '0;
        #3;
        check("rst_busy",    Busy,    1'b0);
        check("rst_done",    Done,    1'b0);
        check("rst_hi",      Hi,      32'h0);
        check("rst_lo",      Lo,      32'h0);
        check("rst_divzero", DivZero, 1'b0);
        check("rst_busy8",   Busy8,   1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back: each directed case is issued in the previous Done cycle.
        dir("mul_uu_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        dir("mul_ss",     0, 1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        dir("mul_uu",     0, 0, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 0);
        dir("div_ss",     1, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        dir("div_uu",     1, 0, 32'd7,         32'd2,         32'd1,         32'd3,         0);
        dir("div_zero",   1, 0, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1);
        dir("div_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
        dir("mul_after",  0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         0);

        // Start re-pulsed mid-operation must not disturb the first result.
        issue(0, 0, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(posedge clk);
        #1 issue(1, 1, 32'h0000_0064, 32'h0000_0003);
        wait_idle();
        check("repulse_hi", Hi, 32'h1);
        check("repulse_lo", Lo, 32'h0);

        // Reset at cycle 10 of an operation aborts it with no Done.
        @(posedge clk); #1;
        issue(0, 0, 32'hDEAD_BEEF, 32'h0000_0010);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", Busy, 1'b0);
        check("abort_hi",   Hi,   32'h0);
        check("abort_lo",   Lo,   32'h0);
        check("abort_done", Done, 1'b0);
        exp_q.delete();
        busy_end = 0;
        held_hi  = '0;
        held_lo  = '0;
        held_dz  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // First Start after reset release is taken on the very next edge.
        dir("post_reset", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        repeat (40) @(posedge clk);
        #1;

        // Randomized traffic, including back-to-back and ignored Starts.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) wait_idle();
            issue($urandom_range(0, 1), $urandom_range(0, 1), pick(), pick());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        // WIDTH=8 instance, scaled cases.
        run8("m8_ss",   0, 1, 8'hFD, 8'd5,  8'hFF, 8'hF1, 0);
        run8("m8_uu",   0, 0, 8'hFD, 8'd5,  8'h04, 8'hF1, 0);
        run8("d8_ss",   1, 1, 8'hF9, 8'd2,  8'hFF, 8'hFD, 0);
        run8("d8_uu",   1, 0, 8'd7,  8'd2,  8'd1,  8'd3,  0);
        run8("d8_ovf",  1, 1, 8'h80, 8'hFF, 8'h00, 8'h80, 0);
        run8("d8_zero", 1, 1, 8'hC3, 8'h00, 8'hC3, 8'hFF, 1);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
